cronometro_lap: RTL and testbench

//  Parametrised stopwatch/timer driven by 4-bit keypad command codes. Counts tenths
//  and seconds from a clock divider, with up-count and preset count-down modes.
//  Has a split (frozen-display) mode and a lap FIFO read by the display/UART path.

---
 rtl/cronometro_lap_if.sv | 27 ++
 rtl/cronometro_lap.sv | 191 +++++++++++++++++++
 tb/tb_cronometro_lap.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/cronometro_lap_if.sv
// Keypad command bus and lap FIFO read port of the stopwatch.
// The master drives commands and pops laps; the slave is the stopwatch itself.
interface cronometro_lap_if #(
  parameter int SEC_W     = 10,
  parameter int LAP_DEPTH = 4
);
  localparam int CW = $clog2(LAP_DEPTH + 1);

  logic [3:0]       cmd;
  logic             cmd_valid;
  logic [SEC_W-1:0] preset_secs;
  logic             lap_rd;
  logic             lap_valid;
  logic [SEC_W+3:0] lap_data;
  logic [CW-1:0]    lap_count;
  logic             lap_ovf;

  modport master (
    output cmd, cmd_valid, preset_secs, lap_rd,
    input  lap_valid, lap_data, lap_count, lap_ovf
  );

  modport slave (
    input  cmd, cmd_valid, preset_secs, lap_rd,
    output lap_valid, lap_data, lap_count, lap_ovf
  );
endinterface

// File: rtl/cronometro_lap.sv
// Keypad-driven stopwatch with a count-down preset, split display and lap FIFO.
// state | meaning:  IDLE cleared | RUN counting, live | LAP counting, frozen | HOLD stopped
module cronometro_lap #(
  parameter int CLK_DIV   = 5000000,
  parameter int SEC_W     = 10,
  parameter int SEC_MAX   = 999,
  parameter int LAP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  cronometro_lap_if.slave   bus,
  output logic [3:0]        disp_tenths,
  output logic [SEC_W-1:0]  disp_secs,
  output logic              running,
  output logic              frozen,
  output logic              down_mode,
  output logic              done,
  output logic              wrap
);
  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int AW = $clog2(LAP_DEPTH);
  localparam int CW = $clog2(LAP_DEPTH + 1);
  localparam logic [DW-1:0]    DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [SEC_W-1:0] SEC_TOP  = SEC_W'(SEC_MAX);
  localparam logic [3:0] C_CLEAR = 4'd10, C_RUN = 4'd11, C_LAP = 4'd12,
                         C_STOP = 4'd13, C_LOAD = 4'd14;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAP, S_HOLD} state_t;

  state_t           state, nxt_state, t_state;
  logic [3:0]       tenths, nxt_tenths, t_tenths, nxt_dt;
  logic [SEC_W-1:0] secs, nxt_secs, t_secs, nxt_ds;
  logic [DW-1:0]    div, nxt_div;
  logic             nxt_down, nxt_done, nxt_wrap, t_done, t_wrap;
  logic             tick, counting, push, flush;

  logic [SEC_W+3:0] mem [LAP_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    fcnt;
  logic             ovf, do_pop, do_push, full;

  assign counting = (state == S_RUN) || (state == S_LAP);
  assign tick     = counting && (div == DIV_LAST);
  assign running  = counting;
  assign frozen   = (state == S_LAP);

  always_comb begin
    t_state  = state;
    t_tenths = tenths;
    t_secs   = secs;
    t_done   = 1'b0;
    t_wrap   = 1'b0;
    nxt_div  = div;
    if (counting) nxt_div = tick ? '0 : div + 1'b1;
    // The tick is resolved first; commands below then act on the post-tick count.
    if (tick) begin
      if (!down_mode) begin
        if (tenths == 4'd9) begin
          t_tenths = 4'd0;
          if (secs == SEC_TOP) begin
            t_secs = '0;
            t_wrap = 1'b1;
          end else begin
            t_secs = secs + 1'b1;
          end
        end else begin
          t_tenths = tenths + 4'd1;
        end
      end else if (tenths != 4'd0 || secs != '0) begin
        if (tenths == 4'd0) begin
          t_tenths = 4'd9;
          t_secs   = secs - 1'b1;
        end else begin
          t_tenths = tenths - 4'd1;
        end
        if (t_tenths == 4'd0 && t_secs == '0) begin
          t_done  = 1'b1;
          t_state = S_HOLD;
        end
      end else begin
        t_state = S_HOLD;
      end
    end

    nxt_state  = t_state;
    nxt_tenths = t_tenths;
    nxt_secs   = t_secs;
    nxt_down   = down_mode;
    nxt_done   = t_done;
    nxt_wrap   = t_wrap;
    push       = 1'b0;
    flush      = 1'b0;
    if (bus.cmd_valid) begin
      case (bus.cmd)
        C_CLEAR: begin
          nxt_state  = S_IDLE;
          nxt_tenths = 4'd0;
          nxt_secs   = '0;
          nxt_div    = '0;
          nxt_down   = 1'b0;
          nxt_done   = 1'b0;
          nxt_wrap   = 1'b0;
          flush      = 1'b1;
        end
        C_RUN:  if (t_state != S_RUN) nxt_state = S_RUN;
        C_LAP: begin
          if (t_state == S_RUN || t_state == S_LAP) begin
            nxt_state = S_LAP;
            push      = 1'b1;
          end
        end
        C_STOP: if (t_state == S_RUN || t_state == S_LAP) nxt_state = S_HOLD;
        C_LOAD: begin
          if (state == S_IDLE || state == S_HOLD) begin
            nxt_state  = S_HOLD;
            nxt_tenths = 4'd0;
            nxt_secs   = bus.preset_secs;
            nxt_div    = '0;
            nxt_down   = 1'b1;
          end
        end
        default: ;
      endcase
    end

    nxt_dt = nxt_tenths;
    nxt_ds = nxt_secs;
    if (nxt_state == S_LAP && !push) begin
      nxt_dt = disp_tenths;
      nxt_ds = disp_secs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      tenths      <= 4'd0;
      secs        <= '0;
      div         <= '0;
      down_mode   <= 1'b0;
      disp_tenths <= 4'd0;
      disp_secs   <= '0;
      done        <= 1'b0;
      wrap        <= 1'b0;
    end else begin
      state       <= nxt_state;
      tenths      <= nxt_tenths;
      secs        <= nxt_secs;
      div         <= nxt_div;
      down_mode   <= nxt_down;
      disp_tenths <= nxt_dt;
      disp_secs   <= nxt_ds;
      done        <= nxt_done;
      wrap        <= nxt_wrap;
    end
  end

  // A pop frees the slot a same-cycle push into a full FIFO needs.
  assign full    = (fcnt == CW'(LAP_DEPTH));
  assign do_pop  = bus.lap_rd && (fcnt != '0) && !flush;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
      ovf    <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      fcnt <= fcnt + 1'b1;
      else if (do_pop && !do_push) fcnt <= fcnt - 1'b1;
      if (push && !do_push) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {t_secs, t_tenths};
  end

  assign bus.lap_valid = (fcnt != '0);
  assign bus.lap_count = fcnt;
  assign bus.lap_ovf   = ovf;
  assign bus.lap_data  = (fcnt != '0) ? mem[rd_ptr] : '0;
endmodule

// File: tb/tb_cronometro_lap.sv
// Scenario bench for cronometro_lap at CLK_DIV=4, SEC_MAX=9, LAP_DEPTH=4.
module tb_cronometro_lap;
  localparam int SW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0]    disp_tenths;
  logic [SW-1:0] disp_secs;
  logic running, frozen, down_mode, done, wrap;
  logic [SW+3:0] dv;
  logic [SW+3:0] exp_lap;
  logic [SW+3:0] sb[$];
  int n_cmp = 0;
  int n_err = 0;

  cronometro_lap_if #(.SEC_W(SW), .LAP_DEPTH(4)) bus();

  cronometro_lap #(.CLK_DIV(4), .SEC_W(SW), .SEC_MAX(9), .LAP_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .disp_tenths(disp_tenths), .disp_secs(disp_secs), .running(running),
    .frozen(frozen), .down_mode(down_mode), .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;
  assign dv = {disp_secs, disp_tenths};

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input logic [3:0] c);
    bus.cmd = c;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd = 4'd0;
  endtask

  task automatic test_reset;
    n_cmp++; if (dv !== 14'd0) begin n_err++; $display("FAIL reset_disp got %h want 0", dv); end
    n_cmp++; if ({running, frozen, down_mode, done, wrap} !== 5'b0) begin n_err++;
      $display("FAIL reset_flags got %b want 00000", {running, frozen, down_mode, done, wrap}); end
    n_cmp++; if ({bus.lap_valid, bus.lap_count, bus.lap_ovf} !== 5'b0) begin n_err++;
      $display("FAIL reset_fifo got %b want 0", {bus.lap_valid, bus.lap_count, bus.lap_ovf}); end
  endtask

  task automatic test_run_stop;
    issue(4'd11);
    wait_n(100);
    n_cmp++; if (dv !== {10'd2, 4'd5}) begin n_err++; $display("FAIL run_2_5 got %h want 0025", dv); end
    n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL run_running got %b want 1", running); end
    issue(4'd13);
    wait_n(6);
    n_cmp++; if (dv !== {10'd2, 4'd5}) begin n_err++; $display("FAIL stop_hold got %h want 0025", dv); end
    n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL stop_running got %b want 0", running); end
    issue(4'd11);
    wait_n(2);
    n_cmp++; if (dv !== {10'd2, 4'd5}) begin n_err++; $display("FAIL resume_early got %h want 0025", dv); end
    wait_n(2);
    n_cmp++; if (dv !== {10'd2, 4'd6}) begin n_err++; $display("FAIL resume_2_6 got %h want 0026", dv); end
  endtask

  task automatic test_wrap;
    int wraps = 0;
    issue(4'd10);
    issue(4'd11);
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (wrap === 1'b1) wraps++;
      if (i == 399) begin
        n_cmp++; if (dv !== {10'd9, 4'd9}) begin n_err++; $display("FAIL wrap_pre got %h want 0099", dv); end
      end
      if (i == 400) begin
        n_cmp++; if (dv !== 14'd0 || wrap !== 1'b1) begin n_err++;
          $display("FAIL wrap_edge got disp %h wrap %b want 0000 1", dv, wrap); end
      end
    end
    n_cmp++; if (wraps != 1) begin n_err++; $display("FAIL wrap_count got %0d want 1", wraps); end
    wait_n(4);
    n_cmp++; if (dv !== {10'd0, 4'd1} || wrap !== 1'b0) begin n_err++;
      $display("FAIL wrap_after got disp %h wrap %b want 0001 0", dv, wrap); end
  endtask

  task automatic test_countdown;
    int dones = 0;
    issue(4'd10);
    bus.preset_secs = 10'd2;
    issue(4'd14);
    n_cmp++; if (dv !== {10'd2, 4'd0} || down_mode !== 1'b1 || running !== 1'b0) begin n_err++;
      $display("FAIL load got disp %h down %b run %b want 0020 1 0", dv, down_mode, running); end
    issue(4'd11);
    wait_n(4);
    n_cmp++; if (dv !== {10'd1, 4'd9}) begin n_err++; $display("FAIL down_first got %h want 0019", dv); end
    for (int i = 5; i <= 80; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
      if (i == 80) begin
        n_cmp++; if (done !== 1'b1 || dv !== 14'd0 || running !== 1'b0) begin n_err++;
          $display("FAIL down_done got done %b disp %h run %b want 1 0000 0", done, dv, running); end
      end
    end
    n_cmp++; if (dones != 1) begin n_err++; $display("FAIL done_count got %0d want 1", dones); end
    wait_n(8);
    n_cmp++; if (done !== 1'b0 || dv !== 14'd0 || running !== 1'b0) begin n_err++;
      $display("FAIL down_settle got done %b disp %h run %b want 0 0000 0", done, dv, running); end
  endtask

  task automatic test_laps;
    issue(4'd10);
    issue(4'd11);
    wait_n(12); sb.push_back({10'd0, 4'd3}); issue(4'd12);
    wait_n(15); sb.push_back({10'd0, 4'd7}); issue(4'd12);
    wait_n(19); sb.push_back({10'd1, 4'd2}); issue(4'd12);
    wait_n(11); sb.push_back({10'd1, 4'd5}); issue(4'd12);
    wait_n(19); issue(4'd12);
    n_cmp++; if (dv !== {10'd2, 4'd0} || frozen !== 1'b1) begin n_err++;
      $display("FAIL lap_freeze got disp %h frozen %b want 0020 1", dv, frozen); end
    n_cmp++; if (bus.lap_count !== 3'd4 || bus.lap_ovf !== 1'b1) begin n_err++;
      $display("FAIL lap_full got count %0d ovf %b want 4 1", bus.lap_count, bus.lap_ovf); end
    wait_n(8);
    n_cmp++; if (dv !== {10'd2, 4'd0}) begin n_err++; $display("FAIL lap_hold got %h want 0020", dv); end
    for (int k = 0; k < 4; k++) begin
      exp_lap = (sb.size() > 0) ? sb.pop_front() : '1;
      n_cmp++; if (bus.lap_valid !== 1'b1 || bus.lap_data !== exp_lap) begin n_err++;
        $display("FAIL lap_pop%0d got valid %b data %h want 1 %h", k, bus.lap_valid, bus.lap_data, exp_lap); end
      bus.lap_rd = 1'b1;
      @(negedge clk);
      bus.lap_rd = 1'b0;
    end
    n_cmp++; if (bus.lap_valid !== 1'b0 || bus.lap_count !== 3'd0) begin n_err++;
      $display("FAIL lap_empty got valid %b count %0d want 0 0", bus.lap_valid, bus.lap_count); end
  endtask

  task automatic test_back_to_back;
    issue(4'd10);
    issue(4'd11);
    wait_n(3);
    sb.push_back({10'd0, 4'd1});
    issue(4'd12);
    issue(4'd12);
    issue(4'd12);
    issue(4'd12);
    issue(4'd12);
    exp_lap = (sb.size() > 0) ? sb.pop_front() : '1;
    n_cmp++; if (bus.lap_data !== exp_lap) begin n_err++;
      $display("FAIL tick_lap got %h want %h", bus.lap_data, exp_lap); end
    n_cmp++; if (dv !== {10'd0, 4'd2} || bus.lap_ovf !== 1'b1 || bus.lap_count !== 3'd4) begin n_err++;
      $display("FAIL tick_split got disp %h ovf %b count %0d want 0002 1 4", dv, bus.lap_ovf, bus.lap_count); end
    wait_n(3);
    bus.lap_rd = 1'b1;
    issue(4'd10);
    bus.lap_rd = 1'b0;
    n_cmp++; if (dv !== 14'd0 || bus.lap_valid !== 1'b0 || bus.lap_count !== 3'd0 || bus.lap_ovf !== 1'b0) begin
      n_err++; $display("FAIL clear_tick got disp %h valid %b count %0d ovf %b want 0000 0 0 0",
                        dv, bus.lap_valid, bus.lap_count, bus.lap_ovf); end
    n_cmp++; if ({running, frozen, wrap, done} !== 4'b0) begin n_err++;
      $display("FAIL clear_flags got %b want 0000", {running, frozen, wrap, done}); end
    issue(4'd11);
    wait_n(5);
    issue(4'd5);
    bus.preset_secs = 10'd7;
    issue(4'd14);
    n_cmp++; if (running !== 1'b1 || down_mode !== 1'b0 || dv !== {10'd0, 4'd1}) begin n_err++;
      $display("FAIL ignore_cmd got run %b down %b disp %h want 1 0 0001", running, down_mode, dv); end
    wait_n(1);
    n_cmp++; if (dv !== {10'd0, 4'd2}) begin n_err++; $display("FAIL ignore_cont got %h want 0002", dv); end
  endtask

  task automatic test_async_reset;
    wait_n(5);
    issue(4'd12);
    wait_n(3);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (dv !== 14'd0 || {running, frozen, down_mode, done, wrap} !== 5'b0) begin n_err++;
      $display("FAIL arst_out got disp %h flags %b want 0", dv, {running, frozen, down_mode, done, wrap}); end
    n_cmp++; if (bus.lap_valid !== 1'b0 || bus.lap_data !== '0 || bus.lap_count !== 3'd0) begin n_err++;
      $display("FAIL arst_fifo got valid %b data %h count %0d want 0", bus.lap_valid, bus.lap_data, bus.lap_count); end
    @(negedge clk);
    rst_n = 1'b1;
    wait_n(8);
    n_cmp++; if (dv !== 14'd0 || running !== 1'b0) begin n_err++;
      $display("FAIL arst_idle got disp %h run %b want 0000 0", dv, running); end
  endtask

  initial begin
    bus.cmd = 4'd0;
    bus.cmd_valid = 1'b0;
    bus.preset_secs = '0;
    bus.lap_rd = 1'b0;
    wait_n(2);
    test_reset();
    rst_n = 1'b1;
    wait_n(1);
    test_run_stop();
    test_wrap();
    test_countdown();
    test_laps();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
